// File: rtl/mem_pkg.sv
// Shared encodings and types for the byte-addressed data memory.
package mem_pkg;

    // Access size encodings, shared with the control unit's data_type decode.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Registered response payload.
    typedef struct packed {
        logic [31:0] rdata;
        logic        misalign;
    } mem_rsp_t;

    // Word-index width for a memory of the given depth in words.
    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane steering: byte enables, store replication, alignment check, load extend.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  byte_en_c_o,
    output logic [31:0] wlanes_c_o,
    output logic        misalign_c_o,
    output logic [31:0] rdata_c_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Decode the access; misaligned or reserved accesses enable no lanes and read 0.
    always_comb begin
        byte_en_c_o  = 4'b0000;
        wlanes_c_o   = 32'h0;
        misalign_c_o = 1'b0;
        rdata_c_o    = 32'h0;
        sel_byte     = rword_i[{addr_lo_i, 3'b000} +: 8];
        sel_half     = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (size_i)
            SZ_BYTE: begin
                byte_en_c_o = 4'b0001 << addr_lo_i;
                wlanes_c_o  = {4{wdata_i[7:0]}};
                rdata_c_o   = unsigned_i ? {24'h0, sel_byte}
                                         : {{24{sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                if (addr_lo_i[0]) begin
                    misalign_c_o = 1'b1;
                end else begin
                    byte_en_c_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wlanes_c_o  = {2{wdata_i[15:0]}};
                    rdata_c_o   = unsigned_i ? {16'h0, sel_half}
                                             : {{16{sel_half[15]}}, sel_half};
                end
            end
            SZ_WORD: begin
                if (addr_lo_i != 2'b00) begin
                    misalign_c_o = 1'b1;
                end else begin
                    byte_en_c_o = 4'b1111;
                    wlanes_c_o  = wdata_i;
                    rdata_c_o   = rword_i;
                end
            end
            default: begin
                misalign_c_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressed MEM-stage data memory with post-reset clear and 1-cycle response.
module byte_data_memory
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned ADDR_W         = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_misalign,
    output logic              init_busy
);

    localparam int unsigned IDX_W = idx_width(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [31:0]      mem_q [DEPTH];
    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             ready_q, busy_q;
    logic             rsp_valid_q, rsp_valid_d;
    mem_rsp_t         rsp_q, rsp_d;

    logic [IDX_W-1:0] idx_c;
    logic [31:0]      rword_c;
    logic [3:0]       byte_en_c;
    logic [31:0]      wlanes_c;
    logic             misalign_c;
    logic [31:0]      load_c;
    logic             accept_c;
    logic             unused_addr_c;

    // Upper address bits fold onto the array (wrap modulo 4*DEPTH bytes).
    assign idx_c         = req_addr[IDX_W+1:2];
    assign unused_addr_c = ^req_addr[ADDR_W-1:IDX_W+2];
    assign rword_c       = mem_q[idx_c];
    assign accept_c      = req_valid & ready_q;

    mem_lane_unit u_lane (
        .size_i       (req_size),
        .addr_lo_i    (req_addr[1:0]),
        .unsigned_i   (req_unsigned),
        .wdata_i      (req_wdata),
        .rword_i      (rword_c),
        .byte_en_c_o  (byte_en_c),
        .wlanes_c_o   (wlanes_c),
        .misalign_c_o (misalign_c),
        .rdata_c_o    (load_c)
    );

    // Next state: clear walks every word once, then the block runs forever.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Response payload: load data only for aligned loads, misalign flag otherwise.
    always_comb begin
        rsp_valid_d = accept_c;
        rsp_d       = '0;
        if (accept_c) begin
            rsp_d.misalign = misalign_c;
            if (!req_write && !misalign_c) begin
                rsp_d.rdata = load_c;
            end
        end
    end

    // Control and response registers; reset drops any pending response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
            cnt_q       <= '0;
            busy_q      <= CLEAR_ON_RESET;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d == ST_INIT);
            ready_q     <= (state_d == ST_RUN);
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    // Storage array: clear writes during INIT, byte-lane stores during RUN.
    always_ff @(posedge clock) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= 32'h0;
        end else if (accept_c && req_write && !misalign_c) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en_c[i]) begin
                    mem_q[idx_c][8*i +: 8] <= wlanes_c[8*i +: 8];
                end
            end
        end
    end

    assign req_ready    = ready_q;
    assign init_busy    = busy_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_q.rdata;
    assign rsp_misalign = rsp_q.misalign;

endmodule
